// File: rtl/div_reservation_unit_pkg.sv
// Shared scheduler types for the divider reservation unit: the FSM state enum and latency constants.
// Latency: radix-2 takes DATA_WIDTH+1 cycles from the start cycle to res_valid; radix-4 takes DATA_WIDTH/2+1.
// Backpressure: none here (types only). Optional macro DIV_RADIX4_EN selects 2 quotient bits per cycle.
package div_reservation_unit_pkg;

  typedef enum logic [1:0] {
    FREE       = 2'd0,
    RESERVED   = 2'd1,
    PROCESSING = 2'd2,
    FINISHED   = 2'd3
  } DivUnitState;

`ifdef DIV_RADIX4_EN
  localparam int DIV_BITS_PER_CYCLE = 2;
`else
  localparam int DIV_BITS_PER_CYCLE = 1;
`endif

  // Cycles from the start cycle until res_valid, for an arbitrary operand width.
  function automatic int div_latency(input int width);
    return width / DIV_BITS_PER_CYCLE + 1;
  endfunction

  // Latency for the default 32-bit datapath.
  localparam int DIV_LATENCY = 32 / DIV_BITS_PER_CYCLE + 1;

endpackage

// File: rtl/div_reservation_unit_iter.sv
// Restoring-division iteration core: partial remainder, quotient shift register and iteration counter.
// Latency: ITERS step cycles after load; 1 (radix-2) or 2 (DIV_RADIX4_EN) quotient bits per step.
// Backpressure: none; the owner FSM gates load/step. Ports: clk, rst (async active-low), load, step,
//   dividend_mag/divisor_mag (unsigned magnitudes), quo/rem (magnitude results), last (final step now).
module div_iter_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ITERS      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend_mag,
  input  logic [DATA_WIDTH-1:0] divisor_mag,
  output logic [DATA_WIDTH-1:0] quo,
  output logic [DATA_WIDTH-1:0] rem,
  output logic                  last
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(ITERS) + 1;

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // One restoring step: shift the next dividend bit (MSB of the quotient register) into the
  // partial remainder and subtract the divisor if it fits. The true difference is always
  // below 2^W, so the W-bit subtraction is exact. Returns {rem, quo}. A zero divisor
  // naturally yields quotient all ones and remainder = dividend magnitude.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r, input logic [W-1:0] q,
                                               input logic [W-1:0] d);
    logic [W:0]   sh;
    logic [W-1:0] diff;
    sh   = {r, q[W-1]};
    diff = sh[W-1:0] - d;
    if (sh >= {1'b0, d}) return {diff, q[W-2:0], 1'b1};
    else                 return {sh[W-1:0], q[W-2:0], 1'b0};
  endfunction

  always_comb begin
    logic [2*W-1:0] nxt;
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    cnt_d = cnt_q;
    nxt   = '0;
    if (load) begin
      rem_d = '0;
      quo_d = dividend_mag;
      div_d = divisor_mag;
      cnt_d = '0;
    end else if (step) begin
      nxt = div_step(rem_q, quo_q, div_q);
`ifdef DIV_RADIX4_EN
      nxt = div_step(nxt[2*W-1:W], nxt[W-1:0], div_q);
`endif
      rem_d = nxt[2*W-1:W];
      quo_d = nxt[W-1:0];
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign quo  = quo_q;
  assign rem  = rem_q;
  assign last = (cnt_q == CW'(ITERS - 1));

endmodule

// File: rtl/div_reservation_unit.sv
// Divider reservation unit: FREE/RESERVED/PROCESSING/FINISHED scheduler FSM plus signed fixup around div_iter_core.
// Latency: res_valid DATA_WIDTH+1 cycles after the start cycle (DATA_WIDTH/2+1 with DIV_RADIX4_EN defined).
// Backpressure: result held in FINISHED until res_ready; flush aborts from any non-FREE state.
// Ports: clk, rst (async active-low); rsv_req/rsv_alp/rsv_ok reservation; cancel, start, dividend,
//   divisor, is_signed, want_rem launch; flush abort; res_valid/res_data/res_ready result; busy, held_alp.
module div_reservation_unit
  import div_reservation_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ALP_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rsv_req,
  input  logic [ALP_WIDTH-1:0]  rsv_alp,
  output logic                  rsv_ok,
  input  logic                  cancel,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  is_signed,
  input  logic                  want_rem,
  input  logic                  flush,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_ready,
  output logic                  busy,
  output logic [ALP_WIDTH-1:0]  held_alp
);

  localparam int W     = DATA_WIDTH;
  localparam int ITERS = div_latency(DATA_WIDTH) - 1;

  DivUnitState          state_q, state_d;
  logic [ALP_WIDTH-1:0] alp_q, alp_d;
  logic                 want_rem_q, want_rem_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic                 div_zero_q, div_zero_d;

  logic         load, step, last;
  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag, quo, rem, q_fix, r_fix;

  assign a_neg = is_signed & dividend[W-1];
  assign b_neg = is_signed & divisor[W-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  always_comb begin
    state_d    = state_q;
    alp_d      = alp_q;
    want_rem_d = want_rem_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    div_zero_d = div_zero_q;
    load       = 1'b0;
    step       = 1'b0;
    case (state_q)
      FREE: begin
        if (rsv_req) begin
          state_d = RESERVED;
          alp_d   = rsv_alp;
        end
      end
      RESERVED: begin
        // flush beats cancel beats start
        if (flush || cancel) begin
          state_d = FREE;
        end else if (start) begin
          state_d    = PROCESSING;
          load       = 1'b1;
          want_rem_d = want_rem;
          q_neg_d    = a_neg ^ b_neg;
          r_neg_d    = a_neg;
          div_zero_d = (divisor == '0);
        end
      end
      PROCESSING: begin
        if (flush) begin
          state_d = FREE;
        end else begin
          step = 1'b1;
          if (last) state_d = FINISHED;
        end
      end
      FINISHED: begin
        if (flush || res_ready) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FREE;
      alp_q      <= '0;
      want_rem_q <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      alp_q      <= alp_d;
      want_rem_q <= want_rem_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      div_zero_q <= div_zero_d;
    end
  end

  div_iter_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ITERS     (ITERS)
  ) u_iter (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .dividend_mag(a_mag),
    .divisor_mag (b_mag),
    .quo         (quo),
    .rem         (rem),
    .last        (last)
  );

  // Divide-by-zero quotient is all ones regardless of signs. MIN / -1 needs no special
  // case: |MIN| / 1 = MIN, and negating MIN yields MIN with remainder 0.
  assign q_fix = div_zero_q ? '1 : (q_neg_q ? -quo : quo);
  assign r_fix = r_neg_q ? -rem : rem;

  assign rsv_ok    = (state_q == FREE);
  assign busy      = (state_q != FREE);
  assign res_valid = (state_q == FINISHED);
  assign res_data  = res_valid ? (want_rem_q ? r_fix : q_fix) : '0;
  assign held_alp  = alp_q;

endmodule

// File: tb/tb_div_reservation_unit.sv
module tb_div_reservation_unit;

`ifdef DIV_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rsv_req = 1'b0;
  logic [5:0]  rsv_alp = '0;
  logic        rsv_ok;
  logic        cancel = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        is_signed = 1'b0;
  logic        want_rem = 1'b0;
  logic        flush = 1'b0;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready = 1'b0;
  logic        busy;
  logic [5:0]  held_alp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_reservation_unit #(.DATA_WIDTH(32), .ALP_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .rsv_req(rsv_req), .rsv_alp(rsv_alp), .rsv_ok(rsv_ok),
    .cancel(cancel), .start(start), .dividend(dividend), .divisor(divisor),
    .is_signed(is_signed), .want_rem(want_rem), .flush(flush), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .busy(busy), .held_alp(held_alp)
  );

  typedef struct {
    logic        sgn;
    logic        rem;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic reserve(input logic [5:0] alp);
    int w = 0;
    while (rsv_ok !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    check("rsv_ok_wait", 32'(rsv_ok), 32'd1);
    rsv_req = 1'b1;
    rsv_alp = alp;
    tick();
    rsv_req = 1'b0;
  endtask

  task automatic launch(input logic sgn, input logic rm, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; is_signed = sgn; want_rem = rm; dividend = a; divisor = b;
    tick();
    start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0; want_rem = 1'b0;
  endtask

  // Cycles counted from the start cycle; a timeout shows up as a latency miscompare.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (res_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic watch_no_valid(input string nm);
    int seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (res_valid === 1'b1) seen++;
      tick();
    end
    check(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{1'b0, 1'b1, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[3]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_1234,  32'd0,          32'h0000_1234};
    vecs[6]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[7]  = '{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[8]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[9]  = '{1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1};
    vecs[10] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'h10,         32'hF};
    vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF};
    vecs[13] = '{1'b1, 1'b1, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8};
    vecs[14] = '{1'b0, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC};
    vecs[15] = '{1'b1, 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE};

    // Reset state
    tick(); tick();
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  res_data,       32'd0);
    check("rst_held_alp",  32'(held_alp),  32'd0);
    check("rst_rsv_ok",    32'(rsv_ok),    32'd1);

    // Reservation on the first edge after release, then cancel racing start
    rst = 1'b1; rsv_req = 1'b1; rsv_alp = 6'd5;
    tick();
    rsv_req = 1'b0;
    check("first_edge_busy", 32'(busy),     32'd1);
    check("first_edge_alp",  32'(held_alp), 32'd5);
    check("reserved_rsv_ok", 32'(rsv_ok),   32'd0);
    cancel = 1'b1; start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    tick();
    cancel = 1'b0; start = 1'b0;
    check("cancel_busy",   32'(busy),   32'd0);
    check("cancel_rsv_ok", 32'(rsv_ok), 32'd1);
    watch_no_valid("cancel_no_valid");

    // Table of full divisions
    for (int i = 0; i < 16; i++) begin
      reserve(6'(i + 5));
      check($sformatf("v%0d_alp", i), 32'(held_alp), 32'(i + 5));
      launch(vecs[i].sgn, vecs[i].rem, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("v%0d_data", i), res_data, vecs[i].exp);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check($sformatf("v%0d_free", i), 32'(busy), 32'd0);
    end

    // Result held under backpressure
    reserve(6'd9);
    launch(1'b0, 1'b0, 32'd1000, 32'd10);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_valid", k), 32'(res_valid), 32'd1);
      check($sformatf("hold%0d_data", k),  res_data,       32'd100);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("hold_release_busy", 32'(busy), 32'd0);

    // Flush at start+10
    reserve(6'd11);
    launch(1'b0, 1'b0, 32'd100, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_proc_busy",   32'(busy),   32'd0);
    check("flush_proc_rsv_ok", 32'(rsv_ok), 32'd1);
    watch_no_valid("flush_proc_no_valid");

    // Flush in RESERVED beats start
    reserve(6'd12);
    flush = 1'b1; start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_rsv_busy", 32'(busy), 32'd0);
    watch_no_valid("flush_rsv_no_valid");

    // Flush in FINISHED beats res_ready
    reserve(6'd13);
    launch(1'b0, 1'b0, 32'd50, 32'd5);
    wait_valid(lat);
    flush = 1'b1; res_ready = 1'b1;
    tick();
    flush = 1'b0; res_ready = 1'b0;
    check("flush_fin_valid", 32'(res_valid), 32'd0);
    check("flush_fin_busy",  32'(busy),      32'd0);

    // Reset at start+20 is seen immediately
    reserve(6'd14);
    launch(1'b0, 1'b0, 32'd100, 32'd7);
    repeat (19) tick();
    rst = 1'b0;
    #1;
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_held_alp",  32'(held_alp),  32'd0);
    check("midrst_rsv_ok",    32'(rsv_ok),    32'd1);
    tick();

    // Reset while a result is held clears res_data at once
    rst = 1'b1;
    reserve(6'd15);
    launch(1'b0, 1'b0, 32'd77, 32'd7);
    wait_valid(lat);
    check("pre_rst_data", res_data, 32'd11);
    rst = 1'b0;
    #1;
    check("finrst_res_data",  res_data,       32'd0);
    check("finrst_res_valid", 32'(res_valid), 32'd0);
    tick();

    // Fresh run right after release
    rst = 1'b1; rsv_req = 1'b1; rsv_alp = 6'd3;
    tick();
    rsv_req = 1'b0;
    check("post_rst_alp", 32'(held_alp), 32'd3);
    launch(1'b0, 1'b0, 32'd9, 32'd3);
    wait_valid(lat);
    check("post_rst_latency", 32'(lat), 32'(LAT));
    check("post_rst_data",    res_data, 32'd3);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("post_rst_free", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
